// File: rtl/load_store_unit.sv
// Sequential RISC-V load/store unit in front of a word-addressed data memory (req/busy/done).
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of ignoring low address bits.
module load_store_unit #(
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       load_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [1:0]  lane_q;
    logic [2:0]  funct3_q;
    logic        is_store_q;
    logic [31:0] store_data_q;
    logic        illegal;
    logic        misalign;

    function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [2:0] f3,
                                                 input logic [1:0] lane);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] b_ext;
        logic signed [31:0] h_ext;
        b     = word[{lane, 3'b000} +: 8];
        h     = word[{lane[1], 4'b0000} +: 16];
        b_ext = 32'(b);
        h_ext = 32'(h);
        case (f3)
            3'b000:  return b_ext;
            3'b001:  return h_ext;
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] lane, input logic [31:0] sd);
        logic [31:0] w;
        w = word;
        case (f3[1:0])
            2'b00:   w[{lane, 3'b000} +: 8]     = sd[7:0];
            2'b01:   w[{lane[1], 4'b0000} +: 16] = sd[15:0];
            default: w = sd;
        endcase
        return w;
    endfunction

    always_comb begin
        illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (is_store && funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
    end

    // Request operands are only consumed after acceptance, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            lane_q       <= addr[1:0];
            funct3_q     <= funct3;
            is_store_q   <= is_store;
            store_data_q <= store_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            load_data <= 32'd0;
            mem_addr  <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_wdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        busy     <= 1'b1;
                        mem_addr <= {addr[ADDR_W-1:2], 2'b00};
                        if (illegal || misalign) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (is_store && funct3[1:0] == 2'b10) begin
                            state     <= WR;
                            mem_write <= 1'b1;
                            mem_wdata <= store_data;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            state    <= RD;
                            mem_read <= 1'b1;
                            cnt      <= 3'(WAIT_CYCLES - 1);
                        end
                    end
                end
                RD: begin
                    if (cnt == 3'd0) begin
                        mem_read <= 1'b0;
                        if (is_store_q) begin
                            state     <= WR;
                            mem_write <= 1'b1;
                            mem_wdata <= merge_store(mem_rdata, funct3_q, lane_q, store_data_q);
                        end else begin
                            state     <= DONE;
                            done      <= 1'b1;
                            load_data <= extract_load(mem_rdata, funct3_q, lane_q);
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                WR: begin
                    mem_write <= 1'b0;
                    state     <= DONE;
                    done      <= 1'b1;
                end
                DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a behavioural memory/ISA model.
module tb_load_store_unit;
    localparam int ADDR_W = 32;
    localparam int WC     = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        busy, done, err, mem_read, mem_write;
    logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:15];
    logic [31:0] ref_mem [0:15];
    logic        bd_we = 1'b0;
    logic [3:0]  bd_idx = 4'd0;
    logic [31:0] bd_data = 32'd0;
    logic [31:0] exp_ld = 32'd0;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .req(req), .is_store(is_store), .funct3(funct3),
        .addr(addr), .store_data(store_data), .busy(busy), .done(done), .err(err),
        .load_data(load_data), .mem_addr(mem_addr), .mem_read(mem_read),
        .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        else if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[5:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] data);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = 4'(idx); bd_data = data;
        @(posedge clk); #1;
        bd_we = 1'b0;
        ref_mem[idx] = data;
    endtask

    function automatic bit is_illegal(input bit st, input int f3);
        return f3 == 3 || f3 == 6 || f3 == 7 || (st && (f3 == 4 || f3 == 5));
    endfunction

    function automatic bit is_misaligned(input int f3, input int a);
`ifdef LSU_MISALIGN_TRAP_EN
        return ((f3 == 1 || f3 == 5) && a % 2 != 0) || (f3 == 2 && a % 4 != 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input int f3, input int a);
        logic [31:0] v;
        int lane = a % 4;
        int hi = (a / 2) % 2;
        case (f3)
            0: begin v = (word >> (8 * lane)) & 32'hFF; if (v >= 128) v = v - 256; end
            4: v = (word >> (8 * lane)) & 32'hFF;
            1: begin v = (word >> (16 * hi)) & 32'hFFFF; if (v >= 32768) v = v - 65536; end
            5: v = (word >> (16 * hi)) & 32'hFFFF;
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] word, input int f3, input int a,
                                                input logic [31:0] sd);
        logic [31:0] mask;
        int lane = a % 4;
        int hi = (a / 2) % 2;
        if (f3 == 0) begin
            mask = 32'hFF << (8 * lane);
            return (word & ~mask) | ((sd & 32'hFF) << (8 * lane));
        end else if (f3 == 1) begin
            mask = 32'hFFFF << (16 * hi);
            return (word & ~mask) | ((sd & 32'hFFFF) << (16 * hi));
        end
        return sd;
    endfunction

    // One transaction; req is held high with scrambled operands until after done.
    task automatic do_access(input bit st, input int f3, input int a, input logic [31:0] sd);
        int idx = (a / 4) % 16;
        int lat, exp_reads, exp_wr;
        bit exp_err;
        logic [31:0] exp_wdata = 32'd0;
        int nreads = 0, first_rd = 0, last_rd = 0, nwr = 0, wr_cyc = 0, done_cyc = 0;
        bit addr_bad = 0, both = 0, busy_bad = 0;
        logic [31:0] got_wdata = 32'd0;
        logic got_err = 1'b0;

        exp_err = 0; exp_reads = 0; exp_wr = 0;
        if (is_illegal(st, f3) || is_misaligned(f3, a)) begin
            exp_err = 1; lat = 1;
        end else if (st && f3 == 2) begin
            lat = 2; exp_wr = 1; exp_wdata = sd;
        end else if (st) begin
            exp_reads = WC; exp_wr = WC + 1; lat = WC + 2;
            exp_wdata = model_store(ref_mem[idx], f3, a, sd);
        end else begin
            exp_reads = WC; lat = WC + 1;
        end

        @(negedge clk);
        req = 1'b1; is_store = st; funct3 = 3'(f3); addr = 32'(a); store_data = sd;
        @(posedge clk); #1;
        for (int c = 1; c <= 20; c++) begin
            is_store = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
            if (mem_read) begin
                nreads++;
                if (first_rd == 0) first_rd = c;
                last_rd = c;
                if (mem_addr !== 32'(a & ~3)) addr_bad = 1;
            end
            if (mem_write) begin
                nwr++; wr_cyc = c; got_wdata = mem_wdata;
                if (mem_addr !== 32'(a & ~3)) addr_bad = 1;
            end
            if (mem_read && mem_write) both = 1;
            if (!busy) busy_bad = 1;
            if (done) begin
                done_cyc = c; got_err = err;
                break;
            end
            @(posedge clk); #1;
        end
        if (!exp_err && !st) exp_ld = model_load(ref_mem[idx], f3, a);
        check("load_data", load_data, exp_ld);
        @(posedge clk); #1;
        req = 1'b0;
        if (exp_wr != 0) ref_mem[idx] = exp_wdata;

        check("done_cycle", 32'(done_cyc), 32'(lat));
        check("err", 32'(got_err), 32'(exp_err));
        check("read_count", 32'(nreads), 32'(exp_reads));
        check("read_window", 32'(first_rd * 100 + last_rd), 32'((exp_reads ? 1 : 0) * 100 + exp_reads));
        check("write_cycle", 32'(nwr * 100 + wr_cyc), 32'((exp_wr ? 1 : 0) * 100 + exp_wr));
        if (exp_wr != 0) check("wdata", got_wdata, exp_wdata);
        check("mem_addr", 32'(addr_bad), 32'd0);
        check("rd_wr_overlap", 32'(both), 32'd0);
        check("busy_during", 32'(busy_bad), 32'd0);
        check("post_done_idle", {28'd0, busy, done, mem_read, mem_write}, 32'd0);
        check("mem_word", mem[idx], ref_mem[idx]);
    endtask

    initial begin
        bit seen;
        #12;
        check("reset_ctrl", {27'd0, busy, done, err, mem_read, mem_write}, 32'd0);
        check("reset_load_data", load_data, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) poke(i, $urandom);

        poke(6, 32'hFFFF0001);
        do_access(0, 2, 'h18, 32'd0);
        check("plan_lw", load_data, 32'hFFFF0001);

        poke(6, 32'h80FF7F01);
        do_access(0, 0, 'h1B, 32'd0);
        check("plan_lb", load_data, 32'hFFFFFF80);
        do_access(0, 4, 'h1B, 32'd0);
        check("plan_lbu", load_data, 32'h00000080);
        do_access(0, 1, 'h1A, 32'd0);
        check("plan_lh", load_data, 32'hFFFF80FF);
        do_access(0, 5, 'h18, 32'd0);
        check("plan_lhu", load_data, 32'h00007F01);

        poke(6, 32'h11223344);
        do_access(1, 0, 'h19, 32'h000000AA);
        check("plan_sb", mem[6], 32'h1122AA44);
        do_access(1, 2, 'h18, 32'hDEADBEEF);
        check("plan_sw", mem[6], 32'hDEADBEEF);

        poke(6, 32'hCAFEF00D);
        do_access(0, 2, 'h1A, 32'd0);
`ifndef LSU_MISALIGN_TRAP_EN
        check("plan_lw_misaligned", load_data, 32'hCAFEF00D);
`endif
        do_access(0, 3, 'h18, 32'd0);

        // Reset while the read-modify-write of an SB is on the memory port.
        poke(6, 32'h55667788);
        @(negedge clk);
        req = 1'b1; is_store = 1'b1; funct3 = 3'd0; addr = 32'h19; store_data = 32'hAA;
        @(posedge clk); #1;
        req = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (mem_write) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        check("rst_wr_seen", 32'(seen), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rst_async_drop", {28'd0, busy, done, mem_read, mem_write}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_ld = 32'd0;
        check("rst_load_data", load_data, 32'd0);
        do_access(0, 2, 'h18, 32'd0);
        check("rst_word_kept", load_data, 32'h55667788);

        for (int n = 0; n < 300; n++)
            do_access(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 63)), $urandom);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential load/store unit sitting directly upstream of the single-cycle core's word-addressed data memory. Accepts one RISC-V load or store request at a time (LB/LH/LW/LBU/LHU/SB/SH/SW), drives the memory's word-wide `Read_data`/`Write_data`/`MemRead`/`MemWrite`/`address` port, performs read-modify-write for sub-word stores, and returns sign- or zero-extended load data. Handshake is req/busy/done.

## Interface
- `ADDR_W`, 32: address width; `mem_addr` is always word-aligned.
- `WAIT_CYCLES`, 1: cycles `mem_read` is held before `mem_rdata` is captured; legal range 1–4.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `req` in 1: start access; sampled only in IDLE.
- `is_store` in 1: 1 = store, 0 = load.
- `funct3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are load-only).
- `addr` in ADDR_W: byte address.
- `store_data` in 32: store operand; low byte/half used for SB/SH.
- `busy` out 1: high in every non-IDLE state.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; access not performed.
- `load_data` out 32: extended load result; updated only on a successful load's `done`, held otherwise.
- `mem_addr` out ADDR_W: `{addr[ADDR_W-1:2],2'b00}`, latched.
- `mem_read` out 1, `mem_write` out 1, `mem_wdata` out 32: to data memory.
- `mem_rdata` in 32: from data memory.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE: on `req`, latch `is_store`, `funct3`, `addr`, `store_data`. Input changes are ignored while `busy`.
- Illegal request (`funct3` ∈ {011,110,111}, or a store with 100/101): IDLE→DONE with `err`=1. No memory access.
- Misaligned request: see Configuration.
- Load: IDLE→RD. `mem_read`=1 for WAIT_CYCLES cycles, driven by a down-counter. `mem_rdata` is captured on the last RD edge. Then →DONE.
- Load extraction, with lane = `addr[1:0]`:
  - LB/LBU: byte at `rdata[8*lane+:8]`, sign- or zero-extended.
  - LH/LHU: half at `rdata[16*addr[1]+:16]`, sign- or zero-extended.
  - LW: full word.
- SW: IDLE→WR. `mem_write`=1 for one cycle, `mem_wdata`=`store_data`. No read. Then →DONE.
- SB/SH: IDLE→RD (same as a load) →WR. `mem_wdata` = captured word with the addressed byte or half replaced by `store_data[7:0]` / `store_data[15:0]`. Then →DONE.
- DONE: `done`=1 for one cycle, then →IDLE. A `req` during DONE is ignored.
- `mem_read` and `mem_write` are never high together.

## Timing
- Reset value of every output is 0, state is IDLE, and the counter is 0.
- Reset mid-operation: all outputs drop asynchronously, and an in-flight `mem_write` is aborted.
- Cycle numbering: `req` is sampled at the edge ending cycle 0.
- Load: `mem_read` high in cycles 1..W; `done` and `load_data` in cycle W+1.
- SW: `mem_write` in cycle 1; `done` in cycle 2.
- SB/SH: `mem_read` in cycles 1..W, `mem_write` in cycle W+1, `done` in cycle W+2.
- Error: `done`=`err`=1 in cycle 1.
- `busy` is high from cycle 1 through the `done` cycle inclusive. Throughput is one request per (latency+1) cycles; the earliest next `req` is sampled in the cycle after `done`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned accesses are trapped.
  - Misaligned means H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0.
  - Such a request goes IDLE→DONE with `err`=1; no `mem_read`/`mem_write`; `load_data` unchanged.
- Undefined: no misalignment check.
  - H ignores `addr[0]`; W ignores `addr[1:0]`.
  - The access proceeds normally; `err` is raised only for illegal `funct3`.

## Test plan
- LW: reset, memory word @0x18 = 0xFFFF0001, `req` LW `addr`=0x18, WAIT_CYCLES=1 → `mem_read` cycle 1, `mem_addr`=0x18, `done` cycle 2, `load_data`=0xFFFF0001, `err`=0.
- Sub-word loads: word @0x18 = 0x80FF7F01.
  - LB 0x1B → 0xFFFFFF80.
  - LBU 0x1B → 0x00000080.
  - LH 0x1A → 0xFFFF80FF.
  - LHU 0x18 → 0x00007F01.
- Stores: word @0x18 = 0x11223344.
  - SB 0x19, data 0x000000AA → single `mem_write`, `mem_wdata`=0x1122AA44, `done` cycle 3.
  - SW 0x18, data 0xDEADBEEF → `mem_write` cycle 1, no `mem_read`, `done` cycle 2.
- Misaligned LW 0x1A:
  - With `LSU_MISALIGN_TRAP_EN`: `done`/`err` cycle 1, no memory strobes.
  - Without: reads 0x18, `err`=0.
- Illegal `funct3`=011: `err`=1 in cycle 1. A second `req` asserted during `busy` is ignored, with no extra memory access.
- Reset during WR of an SB: `mem_write`, `busy`, `done` drop immediately. The next LW completes normally, and the target word is unchanged.
